// File: rtl/alu_issue_ctrl.sv
// Issues one latched command to the selected ALU unit, waits a bounded time for
// its registered result, and holds that result until the consumer accepts it.
module alu_issue_ctrl #(
  parameter int in_width  = 8,
  parameter int out_width = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_fun,
  input  logic [in_width-1:0]  cmd_a,
  input  logic [in_width-1:0]  cmd_b,
  output logic [in_width-1:0]  A,
  output logic [in_width-1:0]  B,
  output logic [1:0]           ALU_FUN,
  output logic                 Arith_Enable,
  output logic                 Logic_Enable,
  output logic                 CMP_Enable,
  output logic                 Shift_Enable,
  input  logic [out_width-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  output logic [out_width-1:0] res_data,
  output logic                 res_err,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           done_count
);

  // state | meaning
  // IDLE  | ready for a command
  // ISSUE | one-cycle enable pulse to the selected unit
  // WAIT  | waiting for OUT_VALID, bounded by TIMEOUT cycles
  // HOLD  | result presented until res_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [3:0]           fun_q, fun_d;
  logic [in_width-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [out_width-1:0] res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic [7:0]           done_q, done_d;
  logic [3:0]           en;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    done_d     = done_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          fun_d   = cmd_fun;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A flag on the last counted cycle still wins over the timeout
        if (OUT_VALID) begin
          res_data_d = ALU_OUT;
          res_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
          if (done_q != 8'hFF) done_d = done_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en = '0;
    if (state_q == ISSUE) en[fun_q[3:2]] = 1'b1;
  end

  assign Arith_Enable = en[0];
  assign Logic_Enable = en[1];
  assign CMP_Enable   = en[2];
  assign Shift_Enable = en[3];
  assign A            = a_q;
  assign B            = b_q;
  assign ALU_FUN      = fun_q[1:0];
  assign cmd_ready    = (state_q == IDLE);
  assign res_valid    = (state_q == HOLD);
  assign res_data     = res_data_q;
  assign res_err      = res_err_q;
  assign done_count   = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a responder plays the ALU units, and a transaction-level
// model predicts every output cycle by cycle; directed cases pin the model.
module tb_alu_issue_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_fun;
  logic [7:0]  cmd_a, cmd_b, A, B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] ALU_OUT, res_data;
  logic        OUT_VALID, res_err, res_valid, res_ready;
  logic [7:0]  done_count;

  alu_issue_ctrl #(.in_width(8), .out_width(16), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable), .CMP_Enable(CMP_Enable),
    .Shift_Enable(Shift_Enable), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
    .res_ready(res_ready), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int cur_d;
  int cd = 0;
  logic [15:0] pend;
  bit chk_on  = 1'b0;
  bit rand_rdy = 1'b0;

  // model state
  bit          m_busy, m_have, m_err;
  int          m_tacc, m_hold, m_d;
  logic [3:0]  m_fun;
  logic [7:0]  m_a, m_b, m_done;
  logic [15:0] m_res;

  wire [3:0] en_vec = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
  wire       any_en = |en_vec;

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa, xb;
    xa = {8'h00, a};
    xb = {8'h00, b};
    case (f)
      4'b0000: return xa + xb;
      4'b0001: return xa - xb;
      4'b0010: return xa * xb;
      4'b0011: return xa ^ xb;
      4'b0100: return xa & xb;
      4'b0101: return xa | xb;
      4'b0110: return {8'h00, ~(a & b)};
      4'b0111: return {8'h00, ~(a | b)};
      4'b1000: return (a == b) ? 16'd1 : 16'd0;
      4'b1001: return (a > b) ? 16'd2 : 16'd0;
      4'b1010: return (a < b) ? 16'd3 : 16'd0;
      4'b1011: return 16'hFFFF;
      4'b1100: return xa >> 1;
      4'b1101: return xa << 1;
      4'b1110: return xa >> 2;
      default: return xa << 2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a command accepted in cycle n issues in n+1, waits from n+2,
  // and presents its result min(delay, TIMEOUT) cycles later.
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      m_busy <= 1'b0;
      m_have <= 1'b0;
      m_done <= 8'd0;
      m_a    <= 8'd0;
      m_b    <= 8'd0;
      m_fun  <= 4'd0;
    end else if (!m_busy && cmd_valid) begin
      m_busy <= 1'b1;
      m_have <= 1'b1;
      m_tacc <= cyc;
      m_fun  <= cmd_fun;
      m_a    <= cmd_a;
      m_b    <= cmd_b;
      m_d    <= cur_d;
      m_hold <= cyc + 2 + ((cur_d < TO) ? cur_d : TO);
      m_res  <= (cur_d <= TO) ? alu_fn(cmd_fun, cmd_a, cmd_b) : 16'h0000;
      m_err  <= (cur_d > TO);
    end else if (m_busy && cyc >= m_hold && res_ready) begin
      m_busy <= 1'b0;
      m_done <= (m_done == 8'hFF) ? 8'hFF : m_done + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !RST) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("enables", en_vec, (m_busy && cyc == m_tacc + 1) ? (4'b0001 << m_fun[3:2]) : 4'b0000);
      chk("res_valid", res_valid, m_busy && cyc >= m_hold);
      chk("done_count", done_count, m_done);
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("ALU_FUN", ALU_FUN, m_fun[1:0]);
      if (m_busy && cyc >= m_hold) begin
        chk("res_data", res_data, m_res);
        chk("res_err", res_err, m_err);
      end
    end
  end

  // Advance to the next cycle and act as the ALU units (registered result, flag
  // delayed by the requested number of cycles after the enable pulse).
  task automatic tick();
    logic [1:0] unit;
    @(negedge clk);
    #1;
    if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
    OUT_VALID = 1'b0;
    ALU_OUT   = 16'($urandom);
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        OUT_VALID = 1'b1;
        ALU_OUT   = pend;
      end
    end else if (!m_busy && $urandom_range(0, 7) == 0) begin
      OUT_VALID = 1'b1;
    end
    if (any_en) begin
      unit = Shift_Enable ? 2'd3 : CMP_Enable ? 2'd2 : Logic_Enable ? 2'd1 : 2'd0;
      pend = alu_fn({unit, ALU_FUN}, A, B);
      cd   = (m_d <= 6) ? m_d : 0;
    end
  endtask

  task automatic offer(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input int d, output int t0);
    bit acc = 1'b0;
    t0 = 0;
    for (int i = 0; i < 60 && !acc; i++) begin
      tick();
      cmd_valid = 1'b1;
      cmd_fun = f; cmd_a = a; cmd_b = b; cur_d = d;
      acc = !m_busy;
      t0 = cyc;
    end
    chk("accept_bound", acc, 1'b1);
  endtask

  task automatic issue_wait(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                            input int d, output int rise, output int pulses);
    int t0;
    rise = -1;
    pulses = 0;
    offer(f, a, b, d, t0);
    for (int i = 0; i < 20 && rise < 0; i++) begin
      tick();
      cmd_valid = 1'b0;
      if (any_en) pulses++;
      if (res_valid) rise = cyc - t0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, pulses, p1, p2, t0, seen;
    RST = 1'b1; cmd_valid = 0; cmd_fun = 0; cmd_a = 0; cmd_b = 0;
    ALU_OUT = 0; OUT_VALID = 0; res_ready = 0; cur_d = 1;
    #3;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_done", done_count, 8'd0);
    chk("rst_enables", en_vec, 4'd0);
    chk("rst_A", A, 8'd0);
    chk("rst_B", B, 8'd0);
    chk("rst_fun", ALU_FUN, 2'd0);
    chk("rst_res_data", res_data, 16'd0);
    chk("rst_res_err", res_err, 1'b0);
    tick(); tick();
    RST = 1'b0;
    chk_on = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1'b1);

    // shift path
    issue_wait(4'b1101, 8'h81, 8'h00, 1, rise, pulses);
    chk("shift_rise", rise, 3);
    chk("shift_pulses", pulses, 1);
    chk("shift_data", res_data, 16'h0102);
    chk("shift_err", res_err, 1'b0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("shift_done", done_count, 8'd1);

    // timeout
    issue_wait(4'b0000, 8'h01, 8'h02, 99, rise, pulses);
    chk("to_rise", rise, 6);
    chk("to_err", res_err, 1'b1);
    chk("to_data", res_data, 16'h0000);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("to_done", done_count, 8'd2);

    // backpressure with a stray command pulse during HOLD
    issue_wait(4'b0000, 8'h12, 8'h34, 2, rise, pulses);
    chk("bp_rise", rise, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      cmd_valid = (i == 3);
      chk("bp_data", res_data, 16'h0046);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("bp_done", done_count, 8'd3);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (any_en) seen++;
    end
    chk("bp_no_accept", seen, 0);

    // back-to-back with res_ready tied high
    res_ready = 1'b1; pulses = 0; p1 = 0; p2 = 0;
    tick();
    cmd_valid = 1'b1; cmd_fun = 4'b0110; cmd_a = 8'h5A; cmd_b = 8'h0F; cur_d = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (any_en) begin
        pulses++;
        if (pulses == 1) p1 = cyc; else p2 = cyc;
      end
      if (pulses >= 2) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_gap", p2 - p1, 4);
    chk("b2b_done", done_count, 8'd5);

    // reset while waiting
    offer(4'b0100, 8'hF0, 8'h3C, 99, t0);
    tick(); cmd_valid = 1'b0;
    tick();
    #2;
    RST = 1'b1;
    cd  = 0;
    #1;
    chk("mr_res_valid", res_valid, 1'b0);
    chk("mr_done", done_count, 8'd0);
    chk("mr_A", A, 8'd0);
    chk("mr_B", B, 8'd0);
    chk("mr_fun", ALU_FUN, 2'd0);
    chk("mr_enables", en_vec, 4'd0);
    tick();
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) seen++;
    end
    chk("mr_no_result", seen, 0);
    chk("mr_done_after", done_count, 8'd0);

    // randomized traffic, enough to saturate done_count
    rand_rdy = 1'b1;
    for (int n = 0; n < 260; n++) begin
      offer(4'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, 6), t0);
      tick();
      cmd_valid = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    rand_rdy = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 40 && m_busy; i++) tick();
    tick();
    res_ready = 1'b0;
    chk("sat_done", done_count, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
